// File: rtl/mux_rr_arb_if.sv
// Channel-side and stream-side signals of the round-robin arbitrating mux.
// Handshake: a source word on lane i is consumed only in a cycle where grant_out[i]=1; data_out is accepted when valid_out & ready_in.
interface mux_rr_arb_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [NUM_CH-1:0]        valid_in;
  logic                     ready_in;
  logic [NUM_CH-1:0]        grant_out;
  logic [DATA_W-1:0]        data_out;
  logic                     valid_out;
  logic [SEL_W-1:0]         sel_out;

  modport master (
    output data_in, valid_in, ready_in,
    input  grant_out, data_out, valid_out, sel_out
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output grant_out, data_out, valid_out, sel_out
  );
endinterface

// File: rtl/mux_rr_arb.sv
// N-channel arbitrating mux: round-robin with bounded bursts, registered output
// stream, combinational one-hot grant feedback and downstream backpressure.
module mux_rr_arb #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic           clk_2f,
  input  logic           reset,
  mux_rr_arb_if.slave    bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              upd;
  logic              sticky;
  logic              found;
  logic [SEL_W-1:0]  scan_g;
  logic [SEL_W-1:0]  g;
  logic [SEL_W-1:0]  idx;
  logic [NUM_CH-1:0] gnt;

  // Search starts one past the last winner so every channel gets its turn.
  always_comb begin
    found  = 1'b0;
    scan_g = last_q;
    idx    = '0;
    for (int s = 1; s <= NUM_CH; s++) begin
      idx = SEL_W'((int'(last_q) + s) % NUM_CH);
      if (!found && bus.valid_in[idx]) begin
        found  = 1'b1;
        scan_g = idx;
      end
    end
  end

  always_comb begin
    upd     = bus.ready_in | ~valid_q;
    sticky  = (cnt_q != '0) && (cnt_q < CNT_W'(BURST_MAX)) && bus.valid_in[last_q];
    g       = sticky ? last_q : scan_g;

    data_d  = data_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt     = '0;

    if (upd) begin
      if (found) begin
        data_d  = bus.data_in[int'(g)*DATA_W +: DATA_W];
        valid_d = 1'b1;
        sel_d   = g;
        last_d  = g;
        cnt_d   = sticky ? cnt_q + 1'b1 : CNT_W'(1);
        gnt[g]  = ~reset;
      end else begin
        // An idle update ends any burst in progress.
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_CH - 1);
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant_out = gnt;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.sel_out   = sel_q;
endmodule
